// File: rtl/ahb3lite_burst_master.sv
// Command-driven AHB-Lite burst master. Takes one command at a time and issues
// SINGLE/INCR/INCRx/WRAPx transfers with pipelined address/data phases,
// honouring HREADY wait states and the two-cycle ERROR response.
module ahb3lite_burst_master #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_INCR  = 16,
  parameter logic [3:0]  HPROT_DEF = 4'b0001
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [2:0]        cmd_burst,
  input  logic [3:0]        cmd_len,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,
  output logic              rd_valid,
  output logic [31:0]       rd_data,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [3:0]        HPROT,
  output logic [31:0]       HWDATA,
  input  logic [31:0]       HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR = 3'd1;

  // S_ADDR: first address phase only; S_BURST: address phase n + data phase n-1;
  // S_LAST: final data phase only; S_ERRC: second cycle of an ERROR response.
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERRC} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic              hwrite_q, hwrite_d;
  logic [2:0]        hsize_q, hsize_d;
  logic [2:0]        hburst_q, hburst_d;
  logic [31:0]       hwdata_q, hwdata_d;
  logic [4:0]        beats_q, beats_d;
  logic [4:0]        left_q, left_d;
  logic              rd_valid_q, rd_valid_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [4:0]        cmd_beats;
  logic              cmd_bad;
  logic [ADDR_W-1:0] nxt_addr;

  function automatic logic [4:0] burst_beats(input logic [2:0] burst, input logic [3:0] len);
    logic [4:0] n;
    case (burst)
      3'd0: n = 5'd1;
      3'd1: begin
        n = {1'b0, len} + 5'd1;
        if (32'(n) > MAX_INCR) n = 5'(MAX_INCR);
      end
      3'd2, 3'd3: n = 5'd4;
      3'd4, 3'd5: n = 5'd8;
      default:    n = 5'd16;
    endcase
    return n;
  endfunction

  function automatic logic is_wrap(input logic [2:0] burst);
    return burst inside {3'd2, 3'd4, 3'd6};
  endfunction

  // Oversized, misaligned, or a fixed-length INCRx that would leave its 1KB page.
  function automatic logic cmd_illegal(input logic [ADDR_W-1:0] addr, input logic [2:0] size,
                                       input logic [2:0] burst, input logic [4:0] beats);
    logic [10:0] span_end;
    logic        misalign;
    span_end = {1'b0, addr[9:0]} + (11'(beats) << size);
    misalign = ((size == 3'd1) && addr[0]) || ((size == 3'd2) && (addr[1:0] != 2'b00));
    return (size > 3'd2) || misalign ||
           ((burst inside {3'd3, 3'd5, 3'd7}) && (span_end > 11'd1024));
  endfunction

  // Wrapping bursts stay inside a beats*(1<<size)-byte aligned block.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [2:0] size, input logic [2:0] burst,
                                                  input logic [4:0] beats);
    logic [ADDR_W-1:0] sum;
    logic [ADDR_W-1:0] mask;
    sum  = addr + (ADDR_W'(1) << size);
    mask = (ADDR_W'(beats) << size) - ADDR_W'(1);
    if (is_wrap(burst)) return (addr & ~mask) | (sum & mask);
    return sum;
  endfunction

  assign cmd_beats = burst_beats(cmd_burst, cmd_len);
  assign cmd_bad   = cmd_illegal(cmd_addr, cmd_size, cmd_burst, cmd_beats);
  assign nxt_addr  = next_addr(haddr_q, hsize_q, hburst_q, beats_q);

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_ready  = ((state_q == S_ADDR) || (state_q == S_BURST)) && hwrite_q && HREADY;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = hburst_q;
  assign HPROT     = HPROT_DEF;
  assign HWDATA    = hwdata_q;

  // Next-state and registered-output logic; everything holds unless HREADY lets the pipe advance.
  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    hsize_d    = hsize_q;
    hburst_d   = hburst_q;
    hwdata_d   = hwdata_q;
    beats_d    = beats_q;
    left_d     = left_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_bad) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            haddr_d  = cmd_addr;
            htrans_d = TR_NONSEQ;
            hwrite_d = cmd_write;
            hsize_d  = cmd_size;
            hburst_d = cmd_burst;
            beats_d  = cmd_beats;
            left_d   = cmd_beats - 5'd1;
            state_d  = S_ADDR;
          end
        end
      end
      S_ADDR, S_BURST: begin
        if (HREADY) begin
          if ((state_q == S_BURST) && !hwrite_q && !HRESP) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
          end
          if (hwrite_q) hwdata_d = wr_data;
          if (left_q == 5'd0) begin
            htrans_d = TR_IDLE;
            state_d  = S_LAST;
          end else begin
            haddr_d  = nxt_addr;
            // An undefined-length INCR restarts with NONSEQ on each 1KB page boundary.
            htrans_d = ((hburst_q == BURST_INCR) && (nxt_addr[9:0] == 10'd0)) ? TR_NONSEQ : TR_SEQ;
            left_d   = left_q - 5'd1;
            state_d  = S_BURST;
          end
        end else if ((state_q == S_BURST) && HRESP) begin
          htrans_d = TR_IDLE;
          state_d  = S_ERRC;
        end
      end
      S_LAST: begin
        if (HREADY) begin
          if (!hwrite_q && !HRESP) begin
            rd_valid_d = 1'b1;
            rd_data_d  = HRDATA;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (HRESP) begin
          state_d = S_ERRC;
        end
      end
      S_ERRC: begin
        if (HREADY) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset forces the bus idle immediately.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      haddr_q    <= '0;
      htrans_q   <= TR_IDLE;
      hwrite_q   <= 1'b0;
      hsize_q    <= 3'd0;
      hburst_q   <= 3'd0;
      hwdata_q   <= 32'd0;
      beats_q    <= 5'd0;
      left_q     <= 5'd0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      hsize_q    <= hsize_d;
      hburst_q   <= hburst_d;
      hwdata_q   <= hwdata_d;
      beats_q    <= beats_d;
      left_q     <= left_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ahb3lite_burst_master.sv
// Directed bench for ahb3lite_burst_master driving a small AHB-Lite memory slave
// with programmable wait states and ERROR injection.
module tb_ahb3lite_burst_master;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'd0;
  logic [2:0]  cmd_size = 3'd0;
  logic [2:0]  cmd_burst = 3'd0;
  logic [3:0]  cmd_len = 4'd0;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  always #5 HCLK = ~HCLK;

  ahb3lite_burst_master #(.ADDR_W(32), .MAX_INCR(16), .HPROT_DEF(4'b0001)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_len(cmd_len),
    .wr_ready(wr_ready), .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  // ---------------- memory slave ----------------
  // Stored words are XORed with an address pattern so never-written locations read back as pat(addr).
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  logic        dp_act = 1'b0;
  logic        dp_write = 1'b0;
  logic        err_ph = 1'b0;
  logic [31:0] dp_addr = 32'd0;
  int unsigned dp_beat = 0;
  int unsigned beat_cnt = 0;
  int unsigned wcnt = 0;
  int unsigned ws_beat = 32'hFFFF_FFFF;
  int unsigned ws_n = 0;
  int unsigned er_beat = 32'hFFFF_FFFF;
  logic [31:0] wbase = 32'd0;
  logic [31:0] wr_cnt = 32'd0;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return {16'hD00D, a[15:0]};
  endfunction

  assign wr_data = wbase + wr_cnt;
  assign HRDATA  = mem[dp_addr[11:2]] ^ pat(dp_addr);

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    if (dp_act) begin
      if (dp_beat == er_beat) begin
        HRESP  = 1'b1;
        HREADY = err_ph;
      end else if ((dp_beat == ws_beat) && (wcnt < ws_n)) begin
        HREADY = 1'b0;
      end
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_act <= 1'b0;
      err_ph <= 1'b0;
      wcnt   <= 0;
    end else if (!HREADY) begin
      if (HRESP) err_ph <= 1'b1;
      else       wcnt   <= wcnt + 1;
    end else begin
      if (dp_act && dp_write && !HRESP) mem[dp_addr[11:2]] <= HWDATA ^ pat(dp_addr);
      err_ph   <= 1'b0;
      wcnt     <= 0;
      dp_act   <= HTRANS[1];
      dp_addr  <= HADDR;
      dp_write <= HWRITE;
      dp_beat  <= beat_cnt;
      if (HTRANS[1]) beat_cnt <= beat_cnt + 1;
    end
  end

  always @(posedge HCLK) if (wr_ready) wr_cnt <= wr_cnt + 32'd1;

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] a_log [$];
  logic [1:0]  t_log [$];
  logic [31:0] r_log [$];
  int          wr_n;
  int          ncyc;
  int          frz_bad;
  logic        dn;
  logic        er;
  logic        rdy_dn;
  logic        dn_after;
  logic [1:0]  tr_err;

  // Issue one command and log completed address phases, read beats and wr_ready pulses until done.
  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [2:0] bu, input logic [3:0] ln);
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic [1:0]  p_trans;
    logic        p_rdy;
    logic        p_resp;
    a_log.delete(); t_log.delete(); r_log.delete();
    wr_n = 0; ncyc = -1; frz_bad = 0; dn = 1'b0; er = 1'b0; rdy_dn = 1'b0; dn_after = 1'b0;
    tr_err = 2'b01;
    cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_burst = bu; cmd_len = ln; cmd_valid = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    p_rdy = 1'b1; p_resp = 1'b0; p_addr = HADDR; p_trans = HTRANS; p_wdata = HWDATA;
    for (int k = 0; k < 80; k++) begin
      if (!p_rdy && !p_resp && ((HADDR !== p_addr) || (HTRANS !== p_trans) || (HWDATA !== p_wdata)))
        frz_bad++;
      if (!p_rdy && p_resp) tr_err = HTRANS;
      if (HTRANS[1] && HREADY) begin
        a_log.push_back(HADDR);
        t_log.push_back(HTRANS);
      end
      if (rd_valid) r_log.push_back(rd_data);
      if (wr_ready) wr_n++;
      if (done) begin
        dn = 1'b1; er = err; rdy_dn = cmd_ready; ncyc = k;
        break;
      end
      p_rdy = HREADY; p_resp = HRESP; p_addr = HADDR; p_trans = HTRANS; p_wdata = HWDATA;
      @(negedge HCLK);
    end
    if (!dn) chk("run_timeout", 32'd0, 32'd1);
    @(negedge HCLK);
    dn_after = done;
  endtask

  task automatic exp_beat(input string tag, input int i, input logic [31:0] a, input logic [1:0] t);
    logic [31:0] ga;
    logic [31:0] gt;
    ga = 32'hDEAD_BEEF;
    gt = 32'hDEAD_BEEF;
    if (i < a_log.size()) begin
      ga = a_log[i];
      gt = 32'(t_log[i]);
    end
    chk($sformatf("%s_addr%0d", tag, i), ga, a);
    chk($sformatf("%s_trans%0d", tag, i), gt, 32'(t));
  endtask

  task automatic exp_rd(input string tag, input int i, input logic [31:0] d);
    logic [31:0] g;
    g = 32'hDEAD_BEEF;
    if (i < r_log.size()) g = r_log[i];
    chk($sformatf("%s_rd%0d", tag, i), g, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge HCLK);
    chk("rst_htrans", 32'(HTRANS), 32'd0);
    chk("rst_haddr", HADDR, 32'd0);
    chk("rst_hwdata", HWDATA, 32'd0);
    chk("rst_hburst_hsize_hwrite", {25'd0, HBURST, HSIZE, HWRITE}, 32'd0);
    chk("rst_hprot", 32'(HPROT), 32'd1);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_pulses", {29'd0, done, rd_valid, wr_ready}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // 1: WRAP4 word write @0x24
    wbase = 32'h0ABB_ABBA - wr_cnt;
    run_cmd(1'b1, 32'h24, 3'd2, 3'd2, 4'd0);
    chk("t1_done", 32'(dn), 32'd1);
    chk("t1_err", 32'(er), 32'd0);
    chk("t1_ready_at_done", 32'(rdy_dn), 32'd1);
    chk("t1_done_pulse", 32'(dn_after), 32'd0);
    chk("t1_wr_ready_n", 32'(wr_n), 32'd4);
    chk("t1_beats", 32'(a_log.size()), 32'd4);
    exp_beat("t1", 0, 32'h24, 2'b10);
    exp_beat("t1", 1, 32'h28, 2'b11);
    exp_beat("t1", 2, 32'h2C, 2'b11);
    exp_beat("t1", 3, 32'h20, 2'b11);
    chk("t1_cycles", 32'(ncyc), 32'd5);

    // 2: WRAP4 read back
    run_cmd(1'b0, 32'h24, 3'd2, 3'd2, 4'd0);
    chk("t2_done_err", {30'd0, dn, er}, 32'd2);
    chk("t2_rd_n", 32'(r_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) exp_rd("t2", i, 32'h0ABB_ABBA + 32'(i));

    // 3a: INCR4 crossing 1KB is rejected without bus activity
    run_cmd(1'b1, 32'h3F8, 3'd2, 3'd3, 4'd0);
    chk("t3a_done_err", {30'd0, dn, er}, 32'd3);
    chk("t3a_no_bus", 32'(a_log.size()), 32'd0);
    chk("t3a_latency", 32'(ncyc), 32'd0);
    chk("t3a_wr_ready_n", 32'(wr_n), 32'd0);

    // 3b: INCR len=3 restarts with NONSEQ at 0x400
    wbase = 32'h1000_0000;
    run_cmd(1'b1, 32'h3F8, 3'd2, 3'd1, 4'd3);
    chk("t3b_done_err", {30'd0, dn, er}, 32'd2);
    chk("t3b_beats", 32'(a_log.size()), 32'd4);
    exp_beat("t3b", 0, 32'h3F8, 2'b10);
    exp_beat("t3b", 1, 32'h3FC, 2'b11);
    exp_beat("t3b", 2, 32'h400, 2'b10);
    exp_beat("t3b", 3, 32'h404, 2'b11);

    // illegal size and misaligned address
    run_cmd(1'b0, 32'h0, 3'd3, 3'd0, 4'd0);
    chk("ill_size", {30'd0, dn, er}, 32'd3);
    chk("ill_size_no_bus", 32'(a_log.size()), 32'd0);
    run_cmd(1'b0, 32'h22, 3'd2, 3'd0, 4'd0);
    chk("ill_align", {30'd0, dn, er}, 32'd3);
    chk("ill_align_no_bus", 32'(a_log.size()), 32'd0);

    // 4: INCR8 read with two wait states on beat 3
    ws_beat = beat_cnt + 2;
    ws_n = 2;
    run_cmd(1'b0, 32'h100, 3'd2, 3'd5, 4'd0);
    ws_beat = 32'hFFFF_FFFF;
    chk("t4_done_err", {30'd0, dn, er}, 32'd2);
    chk("t4_cycles", 32'(ncyc), 32'd11);
    chk("t4_frozen", 32'(frz_bad), 32'd0);
    chk("t4_beats", 32'(a_log.size()), 32'd8);
    chk("t4_rd_n", 32'(r_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) exp_rd("t4", i, pat(32'h100 + 32'(4 * i)));

    // 5: ERROR on beat 2 of WRAP8 read
    er_beat = beat_cnt + 1;
    run_cmd(1'b0, 32'h40, 3'd2, 3'd4, 4'd0);
    er_beat = 32'hFFFF_FFFF;
    chk("t5_done_err", {30'd0, dn, er}, 32'd3);
    chk("t5_ready_at_done", 32'(rdy_dn), 32'd1);
    chk("t5_htrans_after_err", 32'(tr_err), 32'd0);
    chk("t5_beats", 32'(a_log.size()), 32'd2);
    chk("t5_rd_n", 32'(r_log.size()), 32'd1);
    exp_rd("t5", 0, pat(32'h40));
    chk("t5_cycles", 32'(ncyc), 32'd4);

    // 6: reset in the middle of an INCR16 write, then a clean SINGLE write
    wbase = 32'h2000_0000;
    cmd_write = 1'b1; cmd_addr = 32'h200; cmd_size = 3'd2; cmd_burst = 3'd7; cmd_len = 4'd0;
    cmd_valid = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    cmd_addr = 32'h300; cmd_burst = 3'd0; cmd_valid = 1'b1;
    @(negedge HCLK);
    cmd_valid = 1'b0;
    @(negedge HCLK);
    chk("t6_busy_htrans", 32'(HTRANS), 32'd3);
    chk("t6_busy_haddr", HADDR, 32'h20C);
    chk("t6_busy_ready", 32'(cmd_ready), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("t6_rst_htrans", 32'(HTRANS), 32'd0);
    chk("t6_rst_haddr", HADDR, 32'd0);
    chk("t6_rst_hwdata", HWDATA, 32'd0);
    chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    wbase = 32'h5A5A_0001 - wr_cnt;
    run_cmd(1'b1, 32'h20, 3'd2, 3'd0, 4'd0);
    chk("t6_done_err", {30'd0, dn, er}, 32'd2);
    chk("t6_wr_ready_n", 32'(wr_n), 32'd1);
    chk("t6_beats", 32'(a_log.size()), 32'd1);
    exp_beat("t6", 0, 32'h20, 2'b10);
    chk("t6_cycles", 32'(ncyc), 32'd2);
    run_cmd(1'b0, 32'h20, 3'd2, 3'd0, 4'd0);
    chk("t6_rd_n", 32'(r_log.size()), 32'd1);
    exp_rd("t6", 0, 32'h5A5A_0001);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
